uart_coord_receiver: RTL

- Receive-side counterpart to the coordinate telemetry transmitter on the HC-06 Bluetooth link.
- Deserializes 8N1 UART bytes from the RX line, using the shared 16x-oversample baud tick.
- Parses ASCII command lines of the form "<K>:<6 bytes>\n", where K is X, Y or Z.
- Loads the 48-bit payload into the matching coordinate register, so host-side tools can set or override coordinates.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_byte.sv | 133 +++++++++++++
 rtl/uart_coord_receiver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, parser/receiver state types and key decode
package uart_pkg;

  localparam int NBITS         = 8;
  localparam int BAUD_9600_DIV = 325;

  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    P_KEY   = 2'd0,
    P_COLON = 2'd1,
    P_DATA  = 2'd2,
    P_TERM  = 2'd3
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    KEY_X    = 2'd0,
    KEY_Y    = 2'd1,
    KEY_Z    = 2'd2,
    KEY_NONE = 2'd3
  } key_t;

  // Map a received byte to the coordinate it selects; KEY_NONE for non-key bytes.
  function automatic key_t key_of(input logic [7:0] b);
    case (b)
      ASCII_X: key_of = KEY_X;
      ASCII_Y: key_of = KEY_Y;
      ASCII_Z: key_of = KEY_Z;
      default: key_of = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - Rx synchronizer and 8N1 oversampled byte receiver
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             rx,
  output logic [NBITS-1:0] rx_data,
  output logic             byte_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NBITS);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             fall;

  rx_state_t        state, state_d;
  logic [CW-1:0]    tick_cnt, tick_cnt_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [NBITS-1:0] shift, shift_d;
  logic [NBITS-1:0] data_d;
  logic             valid_d;
  logic             ferr_d;

  // Two-flop synchronizer plus one history flop for start-edge detection; idle line is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      tick_cnt   <= tick_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      rx_data    <= data_d;
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
    end
  end

  // Next-state: mid-bit sampling driven by the oversample tick, LSB first.
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    data_d     = rx_data;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync, shift[NBITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_d = RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = RX_IDLE;
            if (rx_sync) begin
              valid_d = 1'b1;
              data_d  = shift;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_coord_receiver.sv
// rtl/uart_coord_receiver.sv - parses "<K>:<6 bytes>\n" lines into X/Y/Z coordinate registers
module uart_coord_receiver
  import uart_pkg::*;
#(
  parameter int          OVERSAMPLE    = 16,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd1600
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Tick,
  input  logic        Rx,
  output logic [47:0] x_coord,
  output logic [47:0] y_coord,
  output logic [47:0] z_coord,
  output logic [2:0]  coord_valid,
  output logic        frame_err,
  output logic        parse_err
);

  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_TICKS - 16'd1;

  logic [7:0]   rx_data;
  logic         byte_valid;

  parse_state_t pstate, pstate_d;
  key_t         key, key_d;
  logic [2:0]   count, count_d;
  logic [47:0]  buffer, buffer_d;
  logic [15:0]  timer, timer_d;
  logic         perr_d;
  logic         commit;
  logic [2:0]   valid_d;

  uart_rx_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .tick      (Tick),
    .rx        (Rx),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Parser state, payload buffer and inter-byte timeout counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pstate    <= P_KEY;
      key       <= KEY_X;
      count     <= '0;
      buffer    <= '0;
      timer     <= '0;
      parse_err <= 1'b0;
    end else begin
      pstate    <= pstate_d;
      key       <= key_d;
      count     <= count_d;
      buffer    <= buffer_d;
      timer     <= timer_d;
      parse_err <= perr_d;
    end
  end

  // Line parser; a received byte always takes priority over a coincident timeout.
  always_comb begin
    pstate_d = pstate;
    key_d    = key;
    count_d  = count;
    buffer_d = buffer;
    timer_d  = timer;
    perr_d   = 1'b0;
    commit   = 1'b0;
    if (byte_valid) begin
      timer_d = '0;
      case (pstate)
        P_KEY: begin
          if (key_of(rx_data) != KEY_NONE) begin
            key_d    = key_of(rx_data);
            pstate_d = P_COLON;
          end
        end
        P_COLON: begin
          if (rx_data == ASCII_COLON) begin
            pstate_d = P_DATA;
            count_d  = '0;
            buffer_d = '0;
          end else begin
            perr_d   = 1'b1;
            pstate_d = P_KEY;
          end
        end
        P_DATA: begin
          if (rx_data == ASCII_LF) begin
            perr_d   = 1'b1;
            pstate_d = P_KEY;
          end else begin
            buffer_d = {buffer[39:0], rx_data};
            count_d  = count + 3'd1;
            if (count == 3'd5) begin
              pstate_d = P_TERM;
            end
          end
        end
        P_TERM: begin
          if (rx_data == ASCII_LF) begin
            commit   = 1'b1;
            pstate_d = P_KEY;
          end else if (rx_data != ASCII_CR) begin
            perr_d   = 1'b1;
            pstate_d = P_KEY;
          end
        end
        default: pstate_d = P_KEY;
      endcase
    end else if (pstate != P_KEY && Tick) begin
      if (timer == TIMEOUT_LAST) begin
        perr_d   = 1'b1;
        pstate_d = P_KEY;
        buffer_d = '0;
        timer_d  = '0;
      end else begin
        timer_d = timer + 16'd1;
      end
    end
  end

  // One-hot commit strobe for the selected coordinate.
  always_comb begin
    valid_d = 3'b000;
    if (commit) begin
      case (key)
        KEY_X:   valid_d = 3'b001;
        KEY_Y:   valid_d = 3'b010;
        KEY_Z:   valid_d = 3'b100;
        default: valid_d = 3'b000;
      endcase
    end
  end

  // Coordinate registers load the buffer in the same cycle their valid bit pulses.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_coord     <= '0;
      y_coord     <= '0;
      z_coord     <= '0;
      coord_valid <= '0;
    end else begin
      coord_valid <= valid_d;
      if (valid_d[0]) x_coord <= buffer;
      if (valid_d[1]) y_coord <= buffer;
      if (valid_d[2]) z_coord <= buffer;
    end
  end

endmodule
